// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dmem_pkg;

  // Access codes; stores reuse codes 0..3 (B/H/W/D) through reqOp[1:0].
  typedef enum logic [2:0] {
    M_LB  = 3'd0,
    M_LH  = 3'd1,
    M_LW  = 3'd2,
    M_LD  = 3'd3,
    M_LBU = 3'd4,
    M_LHU = 3'd5,
    M_LWU = 3'd6,
    M_RSV = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT2 = 2'd1,
    S_RESP  = 2'd2
  } dmem_state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_of(input logic [2:0] op);
    return 4'd1 << op[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store shift and masks for both beats, load merge and extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic [2:0]                  op,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rd_lo,
  input  logic [DATA_W-1:0]           rd_hi,
  output logic [DATA_W-1:0]           wdata_lo_c,
  output logic [DATA_W-1:0]           wdata_hi_c,
  output logic [DATA_W/8-1:0]         mask_lo_c,
  output logic [DATA_W/8-1:0]         mask_hi_c,
  output logic [DATA_W-1:0]           rdata_c
);

  localparam int unsigned NB = DATA_W / 8;

  logic [3:0]          size_c;
  logic [2*DATA_W-1:0] wshift_c;
  logic [2*DATA_W-1:0] rshift_c;
  logic [2*NB-1:0]     mbase_c;
  logic [2*NB-1:0]     mshift_c;
  logic [DATA_W-1:0]   rword_c;
  logic [DATA_W-1:0]   keep_c;
  logic [DATA_W-1:0]   msb_c;
  logic                neg_c;

  // Shift store data/masks across a two-word window; merge and extend load bytes.
  always_comb begin
    size_c   = size_of(op);
    wshift_c = {DATA_W'(0), wdata} << {lane, 3'b000};
    mbase_c  = (2*NB)'((9'd1 << size_c) - 9'd1);
    mshift_c = mbase_c << lane;
    rshift_c = {rd_hi, rd_lo} >> {lane, 3'b000};
    rword_c  = rshift_c[DATA_W-1:0];
    if (32'(size_c) >= NB) begin
      keep_c = '1;
    end else begin
      keep_c = (DATA_W'(1) << {size_c, 3'b000}) - DATA_W'(1);
    end
    msb_c      = keep_c ^ (keep_c >> 1);
    neg_c      = |(rword_c & msb_c);
    wdata_lo_c = wshift_c[DATA_W-1:0];
    wdata_hi_c = wshift_c[2*DATA_W-1:DATA_W];
    mask_lo_c  = mshift_c[NB-1:0];
    mask_hi_c  = mshift_c[2*NB-1:NB];
    rdata_c    = (rword_c & keep_c) | ((neg_c && !op[2]) ? ~keep_c : '0);
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-lane data memory with split handling of word-crossing accesses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 32768,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(32'h8000_0000),
  parameter bit                ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [2:0]        reqOp,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              respValid,
  input  logic              respReady,
  output logic [DATA_W-1:0] respRdata,
  output logic              respErr
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = ADDR_W - LANE_W;
  localparam int unsigned MA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  dmem_state_e       state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MA_W-1:0]   idx2_q, idx2_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic [ADDR_W-1:0] off_c;
  logic [IDX_W-1:0]  idx_c;
  logic [MA_W-1:0]   aidx_c;
  logic [LANE_W-1:0] lane_c;
  logic [2:0]        op_c;
  logic [4:0]        end_c;
  logic              split_c;
  logic              err_c;

  logic [LANE_W-1:0] al_lane_c;
  logic [2:0]        al_op_c;
  logic [DATA_W-1:0] al_wdata_c, al_lo_c, al_hi_c;
  logic [DATA_W-1:0] al_wlo_c, al_whi_c, al_rdata_c;
  logic [NB-1:0]     al_mlo_c, al_mhi_c;

  logic              wr_en_c;
  logic [MA_W-1:0]   wr_idx_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [NB-1:0]     wr_mask_c;

  // Decode the live request: word index, lane, split and error classification.
  always_comb begin
    off_c   = reqAddr - BASE_ADDR;
    idx_c   = off_c[ADDR_W-1:LANE_W];
    aidx_c  = idx_c[MA_W-1:0];
    lane_c  = off_c[LANE_W-1:0];
    op_c    = reqWe ? {1'b0, reqOp[1:0]} : reqOp;
    end_c   = 5'(lane_c) + 5'(size_of(op_c));
    split_c = end_c > 5'(NB);
    err_c   = (reqAddr < BASE_ADDR)
           || ({1'b0, idx_c} >= (IDX_W+1)'(DEPTH))
           || (split_c && (({1'b0, idx_c} + (IDX_W+1)'(1)) >= (IDX_W+1)'(DEPTH)))
           || (split_c && !ALLOW_MISALIGN)
           || (op_c == M_RSV)
           || ((DATA_W == 32) && ((op_c == M_LD) || (op_c == M_LWU)));
  end

  // Feed the aligner from the live request in IDLE, from captured fields in BEAT2.
  always_comb begin
    if (state_q == S_BEAT2) begin
      al_lane_c  = lane_q;
      al_op_c    = op_q;
      al_wdata_c = wdata_q;
      al_lo_c    = rd1_q;
      al_hi_c    = mem_q[idx2_q];
    end else begin
      al_lane_c  = lane_c;
      al_op_c    = op_c;
      al_wdata_c = reqWdata;
      al_lo_c    = mem_q[aidx_c];
      al_hi_c    = '0;
    end
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .lane       (al_lane_c),
    .op         (al_op_c),
    .wdata      (al_wdata_c),
    .rd_lo      (al_lo_c),
    .rd_hi      (al_hi_c),
    .wdata_lo_c (al_wlo_c),
    .wdata_hi_c (al_whi_c),
    .mask_lo_c  (al_mlo_c),
    .mask_hi_c  (al_mhi_c),
    .rdata_c    (al_rdata_c)
  );

  // Next state, response and beat control.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    lane_d       = lane_q;
    op_d         = op_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    idx2_d       = idx2_q;
    rd1_d        = rd1_q;
    wr_en_c      = 1'b0;
    wr_idx_c     = '0;
    wr_data_c    = '0;
    wr_mask_c    = '0;
    case (state_q)
      S_IDLE: begin
        if (reqValid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (err_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else begin
            wr_en_c   = reqWe;
            wr_idx_c  = aidx_c;
            wr_data_c = al_wlo_c;
            wr_mask_c = al_mlo_c;
            if (split_c) begin
              state_d = S_BEAT2;
              lane_d  = lane_c;
              op_d    = op_c;
              we_d    = reqWe;
              wdata_d = reqWdata;
              idx2_d  = aidx_c + MA_W'(1);
              rd1_d   = mem_q[aidx_c];
            end else begin
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              resp_rdata_d = reqWe ? '0 : al_rdata_c;
              resp_err_d   = 1'b0;
            end
          end
        end
      end
      S_BEAT2: begin
        wr_en_c      = we_q;
        wr_idx_c     = idx2_q;
        wr_data_c    = al_whi_c;
        wr_mask_c    = al_mhi_c;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : al_rdata_c;
        resp_err_d   = 1'b0;
      end
      S_RESP: begin
        if (respReady) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers; reset abandons any pending beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      lane_q       <= '0;
      op_q         <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      idx2_q       <= '0;
      rd1_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      lane_q       <= lane_d;
      op_q         <= op_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      idx2_q       <= idx2_d;
      rd1_q        <= rd1_d;
    end
  end

  // Byte-masked array write; contents are not reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_en_c && wr_mask_c[b]) begin
        mem_q[wr_idx_c][b*8 +: 8] <= wr_data_c[b*8 +: 8];
      end
    end
  end

  assign reqReady  = req_ready_q;
  assign respValid = resp_valid_q;
  assign respRdata = resp_rdata_q;
  assign respErr   = resp_err_q;

endmodule
